// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one bus request per access, aligned and extended load return.
// Latency: store 2 cycles, load 3 cycles minimum (IDLE->REQ->WAIT->DONE); misaligned completes in 1.
// Backpressure: request fields stay stable until mem_req_ready; pipeline stall is held until done.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        op_valid,
   input  logic        flush,
   input  logic [63:0] addr,
   input  logic [63:0] store_data,
   input  logic [1:0]  mem_load_type,
   input  logic [1:0]  mem_store_type,
   input  logic        signed_byte,
   input  logic        signed_word,
   output logic        stall,
   output logic        done,
   output logic [63:0] load_data,
   output logic        addr_error,
   output logic        bus_error,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic [7:0]  mem_req_wstrb,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_rdata
);

   // Load and store types share the same size encoding.
   localparam logic [1:0] SZ_NONE  = 2'd0;
   localparam logic [1:0] SZ_BYTE  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state;
   logic [63:0]       addr_q;
   logic [63:0]       store_data_q;
   logic [1:0]        load_type_q;
   logic [1:0]        store_type_q;
   logic              signed_byte_q;
   logic              signed_word_q;
   logic              drop_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              done_q;
   logic              addr_error_q;
   logic              bus_error_q;
   logic [63:0]       load_data_q;

   logic              access;
   logic              start;
   logic [1:0]        size_in;
   logic              misaligned;
   logic              is_store_q;
   logic              timeout_hit;

   // A store wins when both types are set, so its size decides alignment.
   assign access      = op_valid & ((mem_load_type != SZ_NONE) | (mem_store_type != SZ_NONE));
   assign start       = (state == S_IDLE) & access & ~flush;
   assign size_in     = (mem_store_type != SZ_NONE) ? mem_store_type : mem_load_type;
   assign misaligned  = ((size_in == SZ_WORD)  & (addr[1:0] != 2'b00)) |
                        ((size_in == SZ_DWORD) & (addr[2:0] != 3'b000));
   assign is_store_q  = (store_type_q != SZ_NONE);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   // Stall is combinational in IDLE so the pipeline freezes in the issue cycle itself.
   assign stall         = start | (state == S_REQ) | (state == S_WAIT);
   assign mem_req_valid = (state == S_REQ);
   assign mem_req_we    = is_store_q;
   assign mem_req_addr  = {addr_q[63:3], 3'b000};
   assign done          = done_q;
   assign load_data     = load_data_q;
   assign addr_error    = addr_error_q;
   assign bus_error     = bus_error_q;

   // Pick the addressed lane out of the returned doubleword and extend it.
   function automatic logic [63:0] extract(input logic [63:0] rdata,
                                           input logic [2:0]  lane,
                                           input logic [1:0]  ltype,
                                           input logic        sbyte,
                                           input logic        sword);
      logic [7:0]  b;
      logic [31:0] w;
      logic [63:0] r;
      b = rdata[{lane, 3'b000} +: 8];
      w = lane[2] ? rdata[63:32] : rdata[31:0];
      case (ltype)
         SZ_BYTE:  r = {{56{sbyte & b[7]}}, b};
         SZ_WORD:  r = {{32{sword & w[31]}}, w};
         SZ_DWORD: r = rdata;
         default:  r = '0;
      endcase
      return r;
   endfunction

   // Store lanes are replicated across the bus; byte enables select the target bytes.
   always_comb begin
      mem_req_wdata = '0;
      mem_req_wstrb = '0;
      case (store_type_q)
         SZ_BYTE: begin
            mem_req_wdata = {8{store_data_q[7:0]}};
            mem_req_wstrb = 8'b0000_0001 << addr_q[2:0];
         end
         SZ_WORD: begin
            mem_req_wdata = {2{store_data_q[31:0]}};
            mem_req_wstrb = addr_q[2] ? 8'hF0 : 8'h0F;
         end
         SZ_DWORD: begin
            mem_req_wdata = store_data_q;
            mem_req_wstrb = 8'hFF;
         end
         default: ;
      endcase
   end

   // Access sequencer with registered completion outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         addr_q        <= '0;
         store_data_q  <= '0;
         load_type_q   <= SZ_NONE;
         store_type_q  <= SZ_NONE;
         signed_byte_q <= 1'b0;
         signed_word_q <= 1'b0;
         drop_q        <= 1'b0;
         cnt_q         <= '0;
         done_q        <= 1'b0;
         addr_error_q  <= 1'b0;
         bus_error_q   <= 1'b0;
         load_data_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q        <= addr;
                  store_data_q  <= store_data;
                  load_type_q   <= mem_load_type;
                  store_type_q  <= mem_store_type;
                  signed_byte_q <= signed_byte;
                  signed_word_q <= signed_word;
                  drop_q        <= 1'b0;
                  if (misaligned) begin
                     // Never reaches the bus; report straight to the exception path.
                     state        <= S_DONE;
                     done_q       <= 1'b1;
                     addr_error_q <= 1'b1;
                     load_data_q  <= '0;
                  end else begin
                     state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  if (is_store_q) begin
                     // A store accepted in the flush cycle is on the bus, but the
                     // killed instruction gets no completion.
                     if (flush) begin
                        state <= S_IDLE;
                     end else begin
                        state       <= S_DONE;
                        done_q      <= 1'b1;
                        load_data_q <= '0;
                     end
                  end else begin
                     state  <= S_WAIT;
                     cnt_q  <= '0;
                     drop_q <= flush;
                  end
               end else if (flush) begin
                  state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  if (drop_q | flush) begin
                     state <= S_IDLE;
                  end else begin
                     state       <= S_DONE;
                     done_q      <= 1'b1;
                     load_data_q <= extract(mem_resp_rdata, addr_q[2:0], load_type_q,
                                            signed_byte_q, signed_word_q);
                  end
               end else if (timeout_hit) begin
                  if (drop_q | flush) begin
                     state <= S_IDLE;
                  end else begin
                     state       <= S_DONE;
                     done_q      <= 1'b1;
                     bus_error_q <= 1'b1;
                     load_data_q <= '0;
                  end
               end else begin
                  // A flushed load still waits for its response so the bus stays in step.
                  cnt_q  <= cnt_q + CNT_W'(1);
                  drop_q <= drop_q | flush;
               end
            end
            S_DONE: begin
               state        <= S_IDLE;
               done_q       <= 1'b0;
               addr_error_q <= 1'b0;
               bus_error_q  <= 1'b0;
               load_data_q  <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: randomized loads/stores against a byte-addressed reference memory.
// Expected completions are queued at issue and popped by a monitor when done pulses.
// A behavioural bus responder applies random ready hold-off and response delay.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        flush;
   logic [63:0] addr;
   logic [63:0] store_data;
   logic [1:0]  mem_load_type;
   logic [1:0]  mem_store_type;
   logic        signed_byte;
   logic        signed_word;
   logic        stall;
   logic        done;
   logic [63:0] load_data;
   logic        addr_error;
   logic        bus_error;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wstrb;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;

   always #5 clock = ~clock;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clock          (clock),
      .reset          (reset),
      .op_valid       (op_valid),
      .flush          (flush),
      .addr           (addr),
      .store_data     (store_data),
      .mem_load_type  (mem_load_type),
      .mem_store_type (mem_store_type),
      .signed_byte    (signed_byte),
      .signed_word    (signed_word),
      .stall          (stall),
      .done           (done),
      .load_data      (load_data),
      .addr_error     (addr_error),
      .bus_error      (bus_error),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wstrb  (mem_req_wstrb),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [63:0] ld;
      logic        chk_ld;
      logic        ae;
      logic        be;
      int          hs;
   } exp_t;

   exp_t sb_q[$];

   // Reference memory (what the program should see) and the bus-side memory.
   logic [7:0] ref_mem [logic [63:0]];
   logic [7:0] bus_mem [logic [63:0]];

   function automatic logic [7:0] init_byte(input logic [63:0] a);
      return (a[7:0] * 8'd37) + a[10:3];
   endfunction

   function automatic logic [7:0] ref_rd(input logic [63:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] bus_rd(input logic [63:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
   endfunction

   // Responder controls and the request the current op should present.
   int          ready_hold = 0;
   int          resp_delay = 1;
   int          hs_cnt = 0;
   bit          stray_en = 1'b0;
   logic [63:0] exp_req_addr = '0;
   logic [63:0] exp_wdata = '0;
   logic [7:0]  exp_wstrb = '0;
   logic        exp_we = 1'b0;

   // Bus responder: acts on the falling edge so the DUT samples stable inputs.
   initial begin
      int          wait_n;
      int          pend;
      logic [63:0] pend_data;
      wait_n = 0;
      pend = 0;
      pend_data = '0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      forever begin
         @(negedge clock);
         mem_resp_valid = 1'b0;
         if (!reset) begin
            pend = 0;
            wait_n = 0;
            mem_req_ready = 1'b0;
            continue;
         end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_rdata = pend_data;
            end
         end
         if (stray_en && pend == 0 && ($urandom % 6) == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = {$urandom, $urandom};
         end
         if (mem_req_valid) begin
            check("req_addr", mem_req_addr, exp_req_addr);
            check("req_we", {63'd0, mem_req_we}, {63'd0, exp_we});
            if (exp_we) begin
               check("req_wstrb", {56'd0, mem_req_wstrb}, {56'd0, exp_wstrb});
               check("req_wdata", mem_req_wdata, exp_wdata);
            end
            mem_req_ready = (wait_n >= ready_hold);
            wait_n++;
         end else begin
            mem_req_ready = 1'($urandom_range(0, 1));
            wait_n = 0;
         end
         if (mem_req_valid && mem_req_ready) begin
            hs_cnt++;
            wait_n = 0;
            if (mem_req_we) begin
               for (int i = 0; i < 8; i++)
                  if (mem_req_wstrb[i]) bus_mem[mem_req_addr + 64'(i)] = mem_req_wdata[8*i +: 8];
            end else begin
               for (int i = 0; i < 8; i++) pend_data[8*i +: 8] = bus_rd(mem_req_addr + 64'(i));
               pend = resp_delay;
            end
         end
      end
   end

   // Monitor: every done pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: got done=1 with load_data=%h, expected no completion (t=%0t)",
                        load_data, $time);
            end else begin
               e = sb_q.pop_front();
               if (e.chk_ld) check("load_data", load_data, e.ld);
               check("addr_error", {63'd0, addr_error}, {63'd0, e.ae});
               check("bus_error", {63'd0, bus_error}, {63'd0, e.be});
               check("handshakes", 64'(hs_cnt), 64'(e.hs));
               hs_cnt = 0;
            end
         end
      end
   end

   task automatic drive_idle();
      op_valid = 1'b0;
      flush = 1'b0;
      addr = {$urandom, $urandom};
      store_data = {$urandom, $urandom};
      mem_load_type = 2'($urandom_range(0, 3));
      mem_store_type = 2'($urandom_range(0, 3));
      signed_byte = 1'($urandom_range(0, 1));
      signed_word = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clock); #1;
         drive_idle();
         @(negedge clock);
         check("stall_no_op", {63'd0, stall}, 64'd0);
      end
   endtask

   // Issue one access, queue its expected completion and check timing.
   task automatic do_op(input logic st, input logic [1:0] ty, input logic [63:0] a,
                        input logic [63:0] d, input logic sbv, input logic swv,
                        input int hold, input int rdel, input logic both);
      int          n;
      logic        mis;
      exp_t        e;
      logic [63:0] v;
      int          lat;
      int          exp_lat;
      logic        seen;
      n = (ty == 2'd1) ? 1 : (ty == 2'd2) ? 4 : 8;
      mis = (a % 64'(n)) != 0;
      e.ae = mis;
      e.be = 1'b0;
      e.ld = '0;
      e.chk_ld = 1'b0;
      e.hs = mis ? 0 : 1;
      if (!mis && st) begin
         exp_wstrb = '0;
         for (int i = 0; i < n; i++) begin
            ref_mem[a + 64'(i)] = d[8*i +: 8];
            exp_wstrb[int'(a[2:0]) + i] = 1'b1;
         end
         for (int i = 0; i < 8; i++) exp_wdata[8*i +: 8] = d[8*(i % n) +: 8];
      end else if (!mis) begin
         e.chk_ld = 1'b1;
         if (rdel == 0) begin
            e.be = 1'b1;
         end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (64'(ref_rd(a + 64'(i))) << (8 * i));
            if (((n == 1 && sbv) || (n == 4 && swv)) && v[8*n-1]) v = v | (~64'd0 << (8 * n));
            e.ld = v;
         end
      end
      if (mis) exp_lat = 1;
      else if (st) exp_lat = 2 + hold;
      else if (rdel == 0) exp_lat = 2 + hold + TO;
      else exp_lat = 2 + hold + rdel;
      ready_hold = hold;
      resp_delay = rdel;
      exp_req_addr = {a[63:3], 3'b000};
      exp_we = st;
      stray_en = st | mis;
      sb_q.push_back(e);
      @(posedge clock); #1;
      op_valid = 1'b1;
      flush = 1'b0;
      addr = a;
      store_data = d;
      mem_store_type = st ? ty : 2'd0;
      mem_load_type = st ? (both ? 2'($urandom_range(1, 3)) : 2'd0) : ty;
      signed_byte = sbv;
      signed_word = swv;
      @(negedge clock);
      check("stall_on_issue", {63'd0, stall}, 64'd1);
      lat = 0;
      seen = done;
      while (!seen && lat < 60) begin
         @(negedge clock);
         lat++;
         seen = done;
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL done_wait: got no done within %0d cycles, expected done after %0d", lat, exp_lat);
         void'(sb_q.pop_back());
      end else begin
         check("latency", 64'(lat), 64'(exp_lat));
         check("stall_in_done", {63'd0, stall}, 64'd0);
      end
      @(posedge clock); #1;
      drive_idle();
      stray_en = 1'b1;
   endtask

   // Load flushed while waiting: response still arrives but no completion.
   task automatic flush_test();
      stray_en = 1'b0;
      ready_hold = 0;
      resp_delay = 3;
      exp_req_addr = 64'h1010;
      exp_we = 1'b0;
      hs_cnt = 0;
      @(posedge clock); #1;
      op_valid = 1'b1; flush = 1'b0; addr = 64'h1010;
      mem_load_type = 2'd1; mem_store_type = 2'd0;
      @(negedge clock);                // IDLE, issue
      @(posedge clock); #1;            // REQ, handshake this cycle
      @(negedge clock);
      @(posedge clock); #1;            // first WAIT cycle
      flush = 1'b1; op_valid = 1'b0;
      @(negedge clock);
      check("stall_wait_flushed", {63'd0, stall}, 64'd1);
      @(posedge clock); #1;
      flush = 1'b0;
      @(negedge clock);
      @(posedge clock); #1;            // response arrives in this cycle
      @(negedge clock);
      @(posedge clock); #1;
      @(negedge clock);
      check("flush_back_idle", {62'd0, stall, mem_req_valid}, 64'd0);
      idle(3);
      check("flush_handshakes", 64'(hs_cnt), 64'd1);
      hs_cnt = 0;
      stray_en = 1'b1;
   endtask

   task automatic check_all_zero(input string name);
      check(name, {58'd0, stall, done, addr_error, bus_error, mem_req_valid, mem_req_we}, 64'd0);
      check({name, "_addr"}, mem_req_addr, 64'd0);
      check({name, "_wdata"}, mem_req_wdata, 64'd0);
      check({name, "_wstrb"}, {56'd0, mem_req_wstrb}, 64'd0);
      check({name, "_load_data"}, load_data, 64'd0);
   endtask

   // Reset asserted mid-request clears every output without waiting for a clock edge.
   task automatic reset_test();
      stray_en = 1'b0;
      ready_hold = 100;
      exp_req_addr = 64'h2038;
      exp_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
      exp_wstrb = 8'h01;
      exp_we = 1'b1;
      @(posedge clock); #1;
      op_valid = 1'b1; flush = 1'b0; addr = 64'h2038; store_data = 64'hA5;
      mem_store_type = 2'd1; mem_load_type = 2'd0;
      @(negedge clock);
      @(posedge clock); #1;            // now in REQ
      check("req_before_reset", {63'd0, mem_req_valid}, 64'd1);
      #2;
      reset = 1'b0;
      op_valid = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(posedge clock); #1;
      reset = 1'b1;
      ready_hold = 0;
      hs_cnt = 0;
      idle(2);
      stray_en = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      logic        st;
      logic [1:0]  ty;
      logic [63:0] a;
      int          n;
      reset = 1'b0;
      drive_idle();
      op_valid = 1'b0;
      #12;
      check_all_zero("reset_state");
      @(posedge clock); #1;
      reset = 1'b1;
      idle(2);

      // Directed cases.
      do_op(1'b1, 2'd1, 64'h1003, 64'h80, 1'b0, 1'b0, 0, 1, 1'b0);
      do_op(1'b0, 2'd1, 64'h1003, 64'h0, 1'b1, 1'b0, 0, 1, 1'b0);
      do_op(1'b0, 2'd1, 64'h1003, 64'h0, 1'b0, 1'b0, 0, 1, 1'b0);
      do_op(1'b1, 2'd2, 64'h2004, 64'h1122334455667788, 1'b0, 1'b0, 0, 1, 1'b0);
      do_op(1'b0, 2'd3, 64'h3004, 64'h0, 1'b0, 1'b0, 0, 1, 1'b0);
      do_op(1'b0, 2'd2, 64'h2004, 64'h0, 1'b0, 1'b1, 0, 1, 1'b0);
      do_op(1'b1, 2'd3, 64'h2008, 64'hFEDCBA9876543210, 1'b0, 1'b0, 5, 1, 1'b0);
      do_op(1'b0, 2'd3, 64'h2008, 64'h0, 1'b0, 1'b0, 5, 2, 1'b0);
      do_op(1'b0, 2'd2, 64'h200C, 64'h0, 1'b0, 1'b1, 0, 1, 1'b0);
      do_op(1'b0, 2'd2, 64'h1004, 64'h0, 1'b0, 1'b0, 0, 0, 1'b0);
      do_op(1'b1, 2'd2, 64'h1006, 64'h12345678, 1'b0, 1'b0, 0, 1, 1'b0);
      idle(1);
      flush_test();
      do_op(1'b0, 2'd1, 64'h1011, 64'h0, 1'b1, 1'b0, 0, 4, 1'b0);
      reset_test();

      // Randomized traffic over a small window so stores and loads overlap.
      for (int k = 0; k < 300; k++) begin
         st = 1'($urandom_range(0, 1));
         ty = 2'($urandom_range(1, 3));
         n = (ty == 2'd1) ? 1 : (ty == 2'd2) ? 4 : 8;
         a = 64'h1000 + 64'($urandom_range(0, 63));
         if (($urandom % 4) != 0) a = a & ~64'(n - 1);
         do_op(st, ty, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3),
               (($urandom % 8) == 0) ? 0 : $urandom_range(1, 4), 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 2));
      end
      idle(3);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
